ship_placement_overlay: RTL

- Parametrised successor to the single ghost-ship tile overlay.
- Holds a registry of up to NUM_SHIPS committed ships and renders, per VGA pixel, both the live ghost ship and all placed ships.
- Validates placement requests against board bounds and already-placed ships with a sequential checker FSM.
- Sits between the cursor/input controller and the VGA colorizer.

---
 rtl/ship_pkg.sv | 42 ++++
 rtl/ship_segment.sv | 38 +++
 rtl/ship_placement_overlay.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ship_pkg.sv
// Shared types for the ship placement overlay: orientation codes, the
// normalised segment record, the checker FSM states and segment helpers.
package ship_pkg;

    localparam logic [1:0] NORTH = 2'd0;
    localparam logic [1:0] EAST  = 2'd1;
    localparam logic [1:0] SOUTH = 2'd2;
    localparam logic [1:0] WEST  = 2'd3;

    // Normalised ship footprint: (x0,y0) is the top-left tile, (x1,y1) bottom-right.
    typedef struct packed {
        logic signed [5:0] x0;
        logic signed [5:0] y0;
        logic signed [5:0] x1;
        logic signed [5:0] y1;
    } seg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHK,
        S_CHECK,
        S_COMMIT,
        S_REJECT
    } state_t;

    function automatic logic seg_overlap(input seg_t a, input seg_t b);
        return ($signed(a.x0) <= $signed(b.x1)) && ($signed(b.x0) <= $signed(a.x1)) &&
               ($signed(a.y0) <= $signed(b.y1)) && ($signed(b.y0) <= $signed(a.y1));
    endfunction

    function automatic logic signed [11:0] sext12(input logic signed [5:0] v);
        return {{6{v[5]}}, v};
    endfunction

    function automatic logic seg_covers(input seg_t s,
                                        input logic signed [11:0] tx,
                                        input logic signed [11:0] ty);
        return (sext12(s.x0) <= tx) && (tx <= sext12(s.x1)) &&
               (sext12(s.y0) <= ty) && (ty <= sext12(s.y1));
    endfunction

endpackage

// File: rtl/ship_segment.sv
// Combinational cursor/orientation/length to normalised segment conversion,
// with an out-of-board flag. Signed arithmetic keeps off-board ends negative.
module ship_segment
    import ship_pkg::*;
#(
    parameter int GRID_W = 10,
    parameter int GRID_H = 10
) (
    input  logic [7:0] cursor,
    input  logic [1:0] orientation,
    input  logic [2:0] length,
    output seg_t       seg,
    output logic       oob
);

    localparam logic signed [5:0] GW = 6'(GRID_W);
    localparam logic signed [5:0] GH = 6'(GRID_H);

    logic signed [5:0] cx, cy, len;

    assign cx  = $signed({2'b00, cursor[7:4]});
    assign cy  = $signed({2'b00, cursor[3:0]});
    assign len = $signed({3'b000, length});

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        seg = '{x0: cx, y0: cy, x1: cx, y1: cy};
        case (orientation)
            NORTH: seg.y0 = cy - len;
            EAST:  seg.x1 = cx + len;
            SOUTH: seg.y1 = cy + len;
            WEST:  seg.x0 = cx - len;
        endcase
        oob = seg.x0[5] | seg.y0[5] |
              ($signed(seg.x1) >= GW) | ($signed(seg.y1) >= GH);
    end

endmodule

// File: rtl/ship_placement_overlay.sv
// Ghost/placed ship overlay with a registry of committed ships and a sequential
// placement checker. Define SHIP_PLACEMENT_UNDO_EN to enable undo_req.
module ship_placement_overlay
    import ship_pkg::*;
#(
    parameter int NUM_SHIPS  = 5,
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int TILE_SHIFT = 5,
    parameter int IDW        = $clog2(NUM_SHIPS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [9:0]     pixel_x,
    input  logic [9:0]     pixel_y,
    input  logic [7:0]     cursor,
    input  logic [1:0]     orientation,
    input  logic [2:0]     length,
    input  logic           place_req,
    input  logic           undo_req,
    input  logic           clear,
    output logic           ghost_ship,
    output logic           ghost_conflict,
    output logic           placed_ship,
    output logic [IDW-1:0] placed_id,
    output logic           ghost_oob,
    output logic           place_ack,
    output logic           place_nack,
    output logic           busy,
    output logic [IDW-1:0] ships_placed,
    output logic           all_placed
);

    localparam logic [IDW-1:0] FULL = IDW'(NUM_SHIPS);

    state_t         state, state_nxt;
    logic [IDW-1:0] count, count_nxt;
    logic [IDW-1:0] idx, idx_nxt;
    logic [7:0]     lat_cursor;
    logic [1:0]     lat_orient;
    logic [2:0]     lat_len;
    logic           latch_en, wr_en;
    seg_t           req_seg, live_seg;
    logic           req_oob, live_oob;
    seg_t           registry [NUM_SHIPS];

    ship_segment #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_req_seg (
        .cursor      (lat_cursor),
        .orientation (lat_orient),
        .length      (lat_len),
        .seg         (req_seg),
        .oob         (req_oob)
    );

    ship_segment #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_live_seg (
        .cursor      (cursor),
        .orientation (orientation),
        .length      (length),
        .seg         (live_seg),
        .oob         (live_oob)
    );

`ifndef SHIP_PLACEMENT_UNDO_EN
    logic unused_undo;
    assign unused_undo = undo_req;
`endif

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        idx_nxt    = idx;
        latch_en   = 1'b0;
        wr_en      = 1'b0;
        place_ack  = 1'b0;
        place_nack = 1'b0;
        case (state)
            S_IDLE: begin
                if (place_req) begin
                    latch_en  = 1'b1;
                    state_nxt = S_PRECHK;
                end
`ifdef SHIP_PLACEMENT_UNDO_EN
                else if (undo_req && count != '0) begin
                    count_nxt = count - 1'b1;
                end
`endif
            end
            S_PRECHK: begin
                if (count == FULL || req_oob) begin
                    state_nxt = S_REJECT;
                end else if (count == '0) begin
                    state_nxt = S_COMMIT;
                end else begin
                    idx_nxt   = '0;
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (seg_overlap(req_seg, registry[idx])) begin
                    state_nxt = S_REJECT;
                end else if (idx == count - 1'b1) begin
                    state_nxt = S_COMMIT;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            S_COMMIT: begin
                wr_en     = 1'b1;
                count_nxt = count + 1'b1;
                place_ack = 1'b1;
                state_nxt = S_IDLE;
            end
            S_REJECT: begin
                place_nack = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // A wipe aborts any request in flight without reporting it.
        if (clear) begin
            state_nxt  = S_IDLE;
            count_nxt  = '0;
            latch_en   = 1'b0;
            wr_en      = 1'b0;
            place_ack  = 1'b0;
            place_nack = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            count      <= '0;
            idx        <= '0;
            lat_cursor <= '0;
            lat_orient <= '0;
            lat_len    <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            idx   <= idx_nxt;
            if (latch_en) begin
                lat_cursor <= cursor;
                lat_orient <= orientation;
                lat_len    <= length;
            end
        end
    end

    // NOTE: the registry is not reset; entries at or above count are never looked at.
    always_ff @(posedge clk) begin
        if (wr_en) registry[count] <= req_seg;
    end

    assign busy         = (state != S_IDLE);
    assign ships_placed = count;
    assign all_placed   = (count == FULL);

    logic [9:0] tile_x_q, tile_y_q;
    seg_t       ghost_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            ghost_q   <= '0;
            ghost_oob <= 1'b0;
        end else begin
            tile_x_q  <= pixel_x >> TILE_SHIFT;
            tile_y_q  <= pixel_y >> TILE_SHIFT;
            ghost_q   <= live_seg;
            ghost_oob <= live_oob;
        end
    end

    logic signed [11:0]   tx, ty;
    logic                 ghost_hit;
    logic [NUM_SHIPS-1:0] ship_hit;
    logic [IDW-1:0]       hit_id;

    assign tx = $signed({2'b00, tile_x_q});
    assign ty = $signed({2'b00, tile_y_q});

    // Walk downwards so the lowest-indexed hit wins the id.
    always_comb begin
        ghost_hit = seg_covers(ghost_q, tx, ty);
        ship_hit  = '0;
        hit_id    = '0;
        for (int i = NUM_SHIPS - 1; i >= 0; i--) begin
            if ((IDW'(i) < count) && seg_covers(registry[i], tx, ty)) begin
                ship_hit[i] = 1'b1;
                hit_id      = IDW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghost_ship     <= 1'b0;
            ghost_conflict <= 1'b0;
            placed_ship    <= 1'b0;
            placed_id      <= '0;
        end else begin
            ghost_ship     <= ghost_hit;
            ghost_conflict <= ghost_hit & (|ship_hit);
            placed_ship    <= |ship_hit;
            placed_id      <= hit_id;
        end
    end

endmodule
